// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and iteration-kind types for the sequential ALU (alu_seq).
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  typedef enum logic [1:0] {IT_SLL, IT_SRL, IT_SRA, IT_MUL} iter_kind_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the datapath controller (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  // Start is sampled only while Busy=0; once taken, Busy stays high until the
  // op retires and Done pulses for one cycle with G and the flags valid.
  logic             Start;
  logic [3:0]       aluSignal;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] BusWires;
  logic [WIDTH-1:0] G;
  logic             Busy;
  logic             Done;
  logic             Zero;
  logic             Cout;
  logic             Illegal;
  alu_pkg::state_t  dbg_state;

  modport master (
    output Start, aluSignal, A, BusWires,
    input  G, Busy, Done, Zero, Cout, Illegal, dbg_state
  );

  modport slave (
    input  Start, aluSignal, A, BusWires,
    output G, Busy, Done, Zero, Cout, Illegal, dbg_state
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative shifter (1 bit/step) and, with ALU_MUL_EN, a shift-add multiplier.
module alu_iter_unit import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  iter_kind_t       kind_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [CW-1:0]    cnt_in,
  output logic             last,
  output logic [WIDTH-1:0] result
);
  iter_kind_t       kind_q, kind_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
`else
  logic unused_b;
  assign unused_b = ^b_in;
`endif

  always_comb begin
    kind_d = kind_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    if (load) begin
      kind_d = kind_in;
      cnt_d  = cnt_in;
      acc_d  = a_in;
`ifdef ALU_MUL_EN
      mcand_d  = a_in;
      mplier_d = b_in;
      if (kind_in == IT_MUL) acc_d = '0;
`endif
    end else if (step) begin
      cnt_d = cnt_q - 1'b1;
      case (kind_q)
        IT_SLL:  acc_d = {acc_q[WIDTH-2:0], 1'b0};
        IT_SRL:  acc_d = {1'b0, acc_q[WIDTH-1:1]};
        IT_SRA:  acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        default: begin
`ifdef ALU_MUL_EN
          // Product bits above WIDTH are dropped as they shift out of mcand.
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= IT_SLL;
      acc_q  <= '0;
      cnt_q  <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      kind_q <= kind_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign last   = (cnt_q == CW'(1));
  assign result = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with Start/Busy/Done handshake; define ALU_MUL_EN to build the
// iterative multiplier (otherwise opcode 0111 is illegal).
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input logic      Clock,
  input logic      Resetn,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, g_q, g_d;
  logic             zero_q, zero_d, cout_q, cout_d, ill_q, ill_d, done_q, done_d;

  logic             is_shift, is_iter, it_load, it_step, it_last;
  iter_kind_t       it_kind;
  logic [CW-1:0]    shamt, it_cnt;
  logic [WIDTH-1:0] it_result, res;
  logic             res_cout, res_ill;

  always_comb begin : decode
    is_shift = (bus.aluSignal == OP_SLL) || (bus.aluSignal == OP_SRL) ||
               (bus.aluSignal == OP_SRA);
    case (bus.aluSignal)
      OP_SRL:  it_kind = IT_SRL;
      OP_SRA:  it_kind = IT_SRA;
      OP_MUL:  it_kind = IT_MUL;
      default: it_kind = IT_SLL;
    endcase
    // Full bus is the shift amount; anything >= WIDTH saturates to WIDTH steps.
    shamt = (bus.BusWires >= WIDTH'(WIDTH)) ? CW'(WIDTH) : bus.BusWires[CW-1:0];
`ifdef ALU_MUL_EN
    is_iter = is_shift || (bus.aluSignal == OP_MUL);
    it_cnt  = (bus.aluSignal == OP_MUL) ? CW'(WIDTH) : shamt;
`else
    is_iter = is_shift;
    it_cnt  = shamt;
`endif
    it_load = (state_q == S_IDLE) && bus.Start && is_iter;
  end

  alu_iter_unit #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clk     (Clock),
    .rst_n   (Resetn),
    .load    (it_load),
    .step    (it_step),
    .kind_in (it_kind),
    .a_in    (bus.A),
    .b_in    (bus.BusWires),
    .cnt_in  (it_cnt),
    .last    (it_last),
    .result  (it_result)
  );

  always_comb begin : execute
    res      = g_q;
    res_cout = 1'b0;
    res_ill  = 1'b0;
    case (op_q)
      OP_ADD: {res_cout, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        res      = a_q - b_q;
        res_cout = (a_q < b_q);
      end
      OP_OR:  res = a_q | b_q;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL, OP_SRL, OP_SRA: res = it_result;
`ifdef ALU_MUL_EN
      OP_MUL: res = it_result;
`endif
      OP_AND: res = a_q & b_q;
      OP_XOR: res = a_q ^ b_q;
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    it_step = 1'b0;
    case (state_q)
      S_IDLE: if (bus.Start) begin
        op_d    = bus.aluSignal;
        a_d     = bus.A;
        b_d     = bus.BusWires;
        // A zero-length shift has nothing to iterate and retires like a 1-cycle op.
        state_d = (it_load && (it_cnt != '0)) ? S_ITER : S_DONE;
      end
      S_ITER: begin
        it_step = 1'b1;
        if (it_last) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        cout_d  = res_cout;
        ill_d   = res_ill;
        if (!res_ill) begin
          g_d    = res;
          zero_d = (res == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      zero_q  <= 1'b1;
      cout_q  <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end

  assign bus.G         = g_q;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.Done      = done_q;
  assign bus.Zero      = zero_q;
  assign bus.Cout      = cout_q;
  assign bus.Illegal   = ill_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); follows ALU_MUL_EN if defined.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   cyc    = 0;
  int   k_start = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   lat;
  int   extra;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  // clock / cycle counter
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one Start at a negedge; returns #1 after the sampling edge k.
  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.aluSignal = op;
    bus.A         = a;
    bus.BusWires  = b;
    @(posedge clk);
    #1;
    k_start       = cyc;
    bus.Start     = 1'b0;
    bus.A         = 16'($urandom_range(0, 65535));
    bus.BusWires  = 16'($urandom_range(0, 65535));
    check("busy_after_start", {31'b0, bus.Busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, output int l);
    l = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        l = cyc - k_start;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_g, input int exp_lat,
                        input logic exp_cout, input logic exp_ill);
    int l;
    start_op(op, a, b);
    wait_done(40, l);
    check({tag, "_lat"},  32'(l), 32'(exp_lat));
    check({tag, "_g"},    {16'b0, bus.G}, {16'b0, exp_g});
    check({tag, "_zero"}, {31'b0, bus.Zero}, {31'b0, (exp_g == 16'h0000)});
    check({tag, "_cout"}, {31'b0, bus.Cout}, {31'b0, exp_cout});
    check({tag, "_ill"},  {31'b0, bus.Illegal}, {31'b0, exp_ill});
    check({tag, "_busy"}, {31'b0, bus.Busy}, 32'd0);
  endtask

  initial begin
    bus.Start     = 1'b0;
    bus.aluSignal = 4'h0;
    bus.A         = 16'h0;
    bus.BusWires  = 16'h0;

    // asynchronous reset with the clock stopped
    #3 rst_n = 1'b0;
    #1;
    check("rst_g",     {16'b0, bus.G}, 32'h0);
    check("rst_busy",  {31'b0, bus.Busy}, 32'd0);
    check("rst_done",  {31'b0, bus.Done}, 32'd0);
    check("rst_zero",  {31'b0, bus.Zero}, 32'd1);
    check("rst_cout",  {31'b0, bus.Cout}, 32'd0);
    check("rst_ill",   {31'b0, bus.Illegal}, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single-cycle ops
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1'b1, 1'b0);
    run_op("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1, 1'b1, 1'b0);
    run_op("slt_neg", OP_SLT, 16'h8000, 16'h0001, 16'h0001, 1, 1'b0, 1'b0);
    run_op("add_plain", OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1, 1'b0, 1'b0);
    run_op("or", OP_OR, 16'h00F0, 16'h0F0F, 16'h0FFF, 1, 1'b0, 1'b0);
    run_op("and", OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1, 1'b0, 1'b0);
    run_op("xor", OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 1, 1'b0, 1'b0);

    // iterative shifts
    run_op("sra4", OP_SRA, 16'h8010, 16'h0004, 16'hF801, 5, 1'b0, 1'b0);
    run_op("sll_big", OP_SLL, 16'h1234, 16'h0100, 16'h0000, 17, 1'b0, 1'b0);
    run_op("srl15", OP_SRL, 16'h8000, 16'h000F, 16'h0001, 16, 1'b0, 1'b0);
    run_op("sra_big", OP_SRA, 16'h8000, 16'h0020, 16'hFFFF, 17, 1'b0, 1'b0);
    run_op("sll0", OP_SLL, 16'hABCD, 16'h0000, 16'hABCD, 1, 1'b0, 1'b0);
    run_op("sra3_pos", OP_SRA, 16'h7FF0, 16'h0003, 16'h0FFE, 4, 1'b0, 1'b0);

    // multiply (or its illegal fallback)
`ifdef ALU_MUL_EN
    run_op("mul", OP_MUL, 16'h0123, 16'h0010, 16'h1230, 17, 1'b0, 1'b0);
    run_op("mul_wrap", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 17, 1'b0, 1'b0);
`else
    run_op("mul_ill", OP_MUL, 16'h0123, 16'h0010, 16'h0FFE, 1, 1'b0, 1'b1);
`endif

    // Start during Busy and operand changes mid-shift
    start_op(OP_SRL, 16'hF000, 16'h0004);
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.aluSignal = OP_ADD;
    bus.A         = 16'h0001;
    bus.BusWires  = 16'h0001;
    @(negedge clk);
    bus.Start     = 1'b0;
    bus.A         = 16'h0000;
    bus.BusWires  = 16'h0000;
    wait_done(40, lat);
    check("busy_start_lat", 32'(lat), 32'd5);
    check("busy_start_g", {16'b0, bus.G}, 32'h0F00);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.Done) extra++;
    end
    check("busy_start_no_queue", 32'(extra), 32'd0);

    // reset mid-operation
`ifdef ALU_MUL_EN
    start_op(OP_MUL, 16'h0123, 16'h0010);
`else
    start_op(OP_SLL, 16'h00FF, 16'h0010);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_g",     {16'b0, bus.G}, 32'h0);
    check("abort_busy",  {31'b0, bus.Busy}, 32'd0);
    check("abort_zero",  {31'b0, bus.Zero}, 32'd1);
    check("abort_state", 32'(bus.dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.Done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op("add_after_rst", OP_ADD, 16'h1111, 16'h2222, 16'h3333, 1, 1'b0, 1'b0);

    // unsupported opcodes keep G and flag Illegal
    run_op("ill_f", 4'b1111, 16'h0001, 16'h0001, 16'h3333, 1, 1'b0, 1'b1);
    run_op("ill_a", 4'b1010, 16'hFFFF, 16'h0001, 16'h3333, 1, 1'b0, 1'b1);
    run_op("xor_clear", OP_XOR, 16'h3333, 16'h3333, 16'h0000, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
